execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  upstream instruction present.
REQ-004 SHALL have port: in_ready  output  1  stage can accept an instruction this cycle.
REQ-005 SHALL have port: icode  input  4  Y86-64 instruction code.
REQ-006 SHALL have port: ifun  input  4  function code.
REQ-007 SHALL have port: valA, valB, valC  input  64 each  operands from decode; valC is the immediate.
REQ-008 SHALL have port: out_valid  output  1  result register holds a result.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port: valE  output  64  registered ALU result.
REQ-011 SHALL have port: cnd  output  1  registered condition outcome.
REQ-012 SHALL have port: out_err  output  1  registered illegal-instruction flag.
REQ-013 SHALL have port: cc  output  3  condition codes {ZF,SF,OF}.
REQ-014 SHALL have port: halted  output  1  block is in HALTED state.

Function
REQ-015 SHALL accept an instruction when in_valid && in_ready (the accept event); in_ready = state==RUN && (!out_valid || out_ready).
REQ-016 SHALL register valE/cnd/out_err on accept, with out_valid=1 the next cycle (latency 1); with out_ready held high it SHALL sustain one result per cycle.
REQ-017 SHALL hold valE/cnd/out_err stable while out_valid && !out_ready; out_valid SHALL clear after out_ready when no new accept occurs.
REQ-018 SHALL select aluA: valA for icode 2,6; valC for 3,4,5; -8 for 8,A; +8 for 9,B; 0 otherwise.
REQ-019 SHALL select aluB: valB for icode 4,5,6,8,9,A,B; 0 otherwise.
REQ-020 SHALL use ALU op ADD for all icodes except 6; for icode 6, ifun 0..3 SHALL map to ADD, SUB, AND, XOR, with ALU control 00, 01, 10, 11 respectively.
REQ-021 SHALL compute SUB as aluB - aluA, in 64-bit two's complement, wrapping modulo 2^64.
REQ-022 SHALL compute OF:
- ADD: operand signs equal and result sign differs from them.
- SUB: signs of aluB and aluA differ and result sign differs from aluB.
- AND, XOR: 0.
REQ-023 SHALL update cc only on accept of legal icode 6: ZF = result==0, SF = result[63], OF per REQ-022; every other accept leaves cc unchanged.
REQ-024 SHALL evaluate cnd for icode 2 and 7 from cc as held before the same-cycle accept. Per ifun:
- 0: 1
- 1: (SF^OF)|ZF
- 2: SF^OF
- 3: ZF
- 4: !ZF
- 5: !(SF^OF)
- 6: !(SF^OF)&&!ZF
cnd SHALL be 0 for all other icodes.
REQ-025 SHALL flag out_err=1 for: icode > B; icode 6 with ifun > 3; icode 2 or 7 with ifun > 6; icode 0,1,3,4,5,8,9,A,B with ifun != 0. On an illegal instruction valE SHALL be 0, cnd 0 and cc unchanged.
REQ-026 SHALL implement a two-state FSM, RUN and HALTED. RUN->HALTED on accept of icode 0 (legal) or any out_err instruction. HALTED is left only by rst.
REQ-027 SHALL still emit the halting instruction's result (out_valid, out_err as applicable), then keep in_ready=0 while HALTED.
REQ-028 SHALL give rst priority over a simultaneous accept: no result is registered and cc is not updated.

Reset
REQ-029 SHALL on rst drive out_valid=0, valE=0, cnd=0, out_err=0, cc=3'b100 (ZF=1,SF=0,OF=0), state=RUN, halted=0. in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-030 SHALL, on rst asserted mid-stall (out_valid=1, out_ready=0), discard the pending result.

Verification
REQ-031 SHALL pass: OPq add (6/0), valA=0x7FFFFFFFFFFFFFFF, valB=1 -> next cycle valE=0x8000000000000000, cc={0,1,1}.
REQ-032 SHALL pass: OPq sub (6/1), valA=5, valB=5 -> valE=0, cc={1,0,0}; then jXX ifun 3 (je) -> cnd=1.
REQ-033 SHALL pass: pushq (A/0) valB=0x100 -> valE=0xF8, cc unchanged; popq (B/0) valB=0xF8 -> valE=0x100.
REQ-034 SHALL pass: result pending with out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, valE stable, no cc change; out_ready=1 -> next instruction accepted the same cycle.
REQ-035 SHALL pass: icode 6 ifun 7 -> out_err=1, valE=0, halted=1, in_ready=0 thereafter; rst -> cc=3'b100, in_ready=1.
REQ-036 SHALL pass: cmovl (2/2) after sub valA=3, valB=1 (result -2, SF=1, OF=0) -> cnd=1, valE=valA.

Source files
------------

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, branch/cmov condition,
// one-entry registered result with valid/ready handshake, and a RUN/HALTED FSM.
module execute_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [63:0] valA,
   input  logic [63:0] valB,
   input  logic [63:0] valC,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] valE,
   output logic        cnd,
   output logic        out_err,
   output logic [2:0]  cc,
   output logic        halted
);

   typedef enum logic {RUN, HALTED} state_t;
   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_XOR = 2'b11} alu_op_t;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_CMOV   = 4'h2;
   localparam logic [3:0] I_IRMOV  = 4'h3;
   localparam logic [3:0] I_RMMOV  = 4'h4;
   localparam logic [3:0] I_MRMOV  = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSH   = 4'hA;
   localparam logic [3:0] I_POP    = 4'hB;

   state_t        state, state_nxt;
   alu_op_t       alu_op;
   logic          accept;
   logic          legal;
   logic [63:0]   alu_a, alu_b, alu_r;
   logic          alu_of;
   logic          zf, sf, of;
   logic          cond;
   logic          cnd_raw;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign halted   = (state == HALTED);
   assign zf       = cc[2];
   assign sf       = cc[1];
   assign of       = cc[0];

   always_comb begin
      legal = 1'b0;
      unique case (icode)
         I_OPQ:         legal = (ifun <= 4'd3);
         I_CMOV, I_JXX: legal = (ifun <= 4'd6);
         4'hC, 4'hD, 4'hE, 4'hF: legal = 1'b0;
         default:       legal = (ifun == 4'd0);
      endcase
   end

   always_comb begin
      alu_a = '0;
      alu_b = '0;
      unique case (icode)
         I_CMOV, I_OPQ:           alu_a = valA;
         I_IRMOV, I_RMMOV, I_MRMOV: alu_a = valC;
         I_CALL, I_PUSH:          alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
         I_RET, I_POP:            alu_a = 64'd8;
         default:                 alu_a = '0;
      endcase
      unique case (icode)
         I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = valB;
         default: alu_b = '0;
      endcase
      alu_op = (icode == I_OPQ) ? alu_op_t'(ifun[1:0]) : ALU_ADD;
   end

   always_comb begin
      alu_r  = '0;
      alu_of = 1'b0;
      unique case (alu_op)
         ALU_ADD: begin
            alu_r  = alu_b + alu_a;
            alu_of = (alu_a[63] == alu_b[63]) && (alu_r[63] != alu_a[63]);
         end
         ALU_SUB: begin
            alu_r  = alu_b - alu_a;
            alu_of = (alu_b[63] != alu_a[63]) && (alu_r[63] != alu_b[63]);
         end
         ALU_AND: alu_r = alu_b & alu_a;
         ALU_XOR: alu_r = alu_b ^ alu_a;
      endcase
   end

   // Condition is taken from the codes already held, never the ones this accept produces.
   always_comb begin
      cond = 1'b0;
      case (ifun)
         4'd0:    cond = 1'b1;
         4'd1:    cond = (sf ^ of) | zf;
         4'd2:    cond = sf ^ of;
         4'd3:    cond = zf;
         4'd4:    cond = !zf;
         4'd5:    cond = !(sf ^ of);
         4'd6:    cond = !(sf ^ of) && !zf;
         default: cond = 1'b0;
      endcase
      cnd_raw = legal && ((icode == I_CMOV) || (icode == I_JXX)) && cond;
   end

   always_comb begin
      state_nxt = state;
      if (accept && (!legal || icode == I_HALT))
         state_nxt = HALTED;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         out_valid <= 1'b0;
         valE      <= '0;
         cnd       <= 1'b0;
         out_err   <= 1'b0;
         cc        <= 3'b100;
      end else begin
         state <= state_nxt;
         if (accept) begin
            out_valid <= 1'b1;
            valE      <= legal ? alu_r : '0;
            cnd       <= cnd_raw;
            out_err   <= !legal;
            if (legal && icode == I_OPQ)
               cc <= {(alu_r == 64'd0), alu_r[63], alu_of};
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized bench for execute_stage: an independent reference model
// feeds a result scoreboard that is compared whenever the model expects a result.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  icode, ifun;
   logic [63:0] valA, valB, valC;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] valE;
   logic        cnd, out_err;
   logic [2:0]  cc;
   logic        halted;

   execute_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
      .out_valid(out_valid), .out_ready(out_ready), .valE(valE), .cnd(cnd),
      .out_err(out_err), .cc(cc), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] e;
      logic        c;
      logic        err;
   } exp_t;

   exp_t        q[$];
   logic        m_ov   = 1'b0;
   logic        m_halt = 1'b0;
   logic [2:0]  m_cc   = 3'b100;
   logic        chk_en = 1'b0;
   int          n_asrt = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_asrt++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   // Reference semantics written per instruction rather than per datapath mux.
   function automatic exp_t model(input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                  input logic [2:0] cin, output logic [2:0] cout, output logic hlt);
      exp_t        r;
      logic        ok, z, s, o, t;
      logic [64:0] w;
      r.e = '0; r.c = 1'b0; r.err = 1'b0;
      cout = cin;
      z = cin[2]; s = cin[1]; o = cin[0];
      ok = (ic <= 4'hB) && ((ic == 4'h6) ? (fn <= 4'd3) :
                            (ic == 4'h2 || ic == 4'h7) ? (fn <= 4'd6) : (fn == 4'd0));
      hlt = !ok || (ic == 4'h0);
      if (!ok) begin
         r.err = 1'b1;
         return r;
      end
      case (fn)
         4'd0: t = 1'b1;
         4'd1: t = (s != o) || z;
         4'd2: t = (s != o);
         4'd3: t = z;
         4'd4: t = !z;
         4'd5: t = (s == o);
         default: t = (s == o) && !z;
      endcase
      case (ic)
         4'h2: begin r.e = a; r.c = t; end
         4'h3: r.e = c;
         4'h4, 4'h5: r.e = b + c;
         4'h7: r.c = t;
         4'h8, 4'hA: r.e = b - 64'd8;
         4'h9, 4'hB: r.e = b + 64'd8;
         4'h6: begin
            o = 1'b0;
            case (fn)
               4'd0: begin w = {b[63], b} + {a[63], a}; r.e = w[63:0]; o = w[64] ^ w[63]; end
               4'd1: begin w = {b[63], b} - {a[63], a}; r.e = w[63:0]; o = w[64] ^ w[63]; end
               4'd2: r.e = a & b;
               default: r.e = a ^ b;
            endcase
            cout = {(r.e == 64'd0), r.e[63], o};
         end
         default: r.e = '0;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      logic       acc, h;
      logic [2:0] ncc;
      exp_t       x;
      if (rst) begin
         m_ov = 1'b0; m_halt = 1'b0; m_cc = 3'b100;
         q.delete();
      end else begin
         acc = in_valid && !m_halt && (!m_ov || out_ready);
         if (m_ov && out_ready && q.size() > 0) void'(q.pop_front());
         if (acc) begin
            x = model(icode, ifun, valA, valB, valC, m_cc, ncc, h);
            q.push_back(x);
            m_cc = ncc;
            if (h) m_halt = 1'b1;
            m_ov = 1'b1;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", {63'd0, in_ready}, {63'd0, !m_halt && (!m_ov || out_ready)});
         check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
         check("cc", {61'd0, cc}, {61'd0, m_cc});
         check("halted", {63'd0, halted}, {63'd0, m_halt});
         if (m_ov && q.size() > 0) begin
            check("sb_valE", valE, q[0].e);
            check("sb_cnd", {63'd0, cnd}, {63'd0, q[0].c});
            check("sb_err", {63'd0, out_err}, {63'd0, q[0].err});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      in_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
   endtask

   logic [3:0] legal_ic [11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
   logic [3:0] bad_ic   [4]  = '{4'h7, 4'hC, 4'h1, 4'h0};
   logic [3:0] bad_fn   [4]  = '{4'h7, 4'h0, 4'h1, 4'h0};

   initial begin
      rst = 1'b1; out_ready = 1'b1;
      drive(1'b0, 4'h1, 4'h0, '0, '0, '0);
      step(2);
      rst = 1'b0; chk_en = 1'b1;
      check("rst_valE", valE, 64'd0);
      check("rst_cnd", {63'd0, cnd}, 64'd0);
      check("rst_err", {63'd0, out_err}, 64'd0);
      check("rst_cc", {61'd0, cc}, 64'd4);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);

      drive(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0);
      step(1);
      check("add_ovf_valE", valE, 64'h8000_0000_0000_0000);
      check("add_ovf_cc", {61'd0, cc}, 64'd3);

      drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, '0);
      step(1);
      check("sub_zero_valE", valE, 64'd0);
      check("sub_zero_cc", {61'd0, cc}, 64'd4);
      drive(1'b1, 4'h7, 4'h3, '0, '0, 64'h400);
      step(1);
      check("je_cnd", {63'd0, cnd}, 64'd1);

      drive(1'b1, 4'h6, 4'h1, 64'd3, 64'd1, '0);
      step(1);
      check("sub_neg_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_neg_cc", {61'd0, cc}, 64'd2);
      drive(1'b1, 4'h2, 4'h2, 64'h1234, 64'h9999, '0);
      step(1);
      check("cmovl_cnd", {63'd0, cnd}, 64'd1);
      check("cmovl_valE", valE, 64'h1234);

      drive(1'b1, 4'hA, 4'h0, 64'h55, 64'h100, '0);
      step(1);
      check("push_valE", valE, 64'hF8);
      check("push_cc", {61'd0, cc}, 64'd2);
      drive(1'b1, 4'hB, 4'h0, 64'h55, 64'hF8, '0);
      step(1);
      check("pop_valE", valE, 64'h100);

      for (int i = 0; i < 60; i++) begin
         logic [3:0] ic, fn;
         ic = legal_ic[$urandom_range(0, 10)];
         fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) :
              (ic == 4'h2 || ic == 4'h7) ? 4'($urandom_range(0, 6)) : 4'd0;
         out_ready = ($urandom_range(0, 9) < 7);
         if (i % 5 == 0)
            drive($urandom_range(0, 3) != 0, ic, fn, 64'($urandom_range(0, 3)), 64'($urandom_range(0, 3)), 64'd8);
         else
            drive($urandom_range(0, 3) != 0, ic, fn, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         step(1);
      end
      out_ready = 1'b1;
      drive(1'b0, 4'h1, 4'h0, '0, '0, '0);
      step(1);

      out_ready = 1'b0;
      drive(1'b1, 4'h6, 4'h1, 64'd3, 64'd10, '0);
      step(1);
      drive(1'b1, 4'h6, 4'h0, 64'd5, 64'd6, '0);
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
         check("stall_valE", valE, 64'd7);
         check("stall_cc", {61'd0, cc}, 64'd0);
         step(1);
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", {63'd0, in_ready}, 64'd1);
      step(1);
      check("release_valE", valE, 64'd11);

      out_ready = 1'b0;
      drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, '0);
      step(1);
      in_valid = 1'b0; rst = 1'b1;
      step(1);
      rst = 1'b0; out_ready = 1'b1;
      check("rst_stall_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_stall_valE", valE, 64'd0);

      rst = 1'b1;
      drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, '0);
      step(1);
      in_valid = 1'b0; rst = 1'b0;
      check("rst_prio_cc", {61'd0, cc}, 64'd4);
      check("rst_prio_out_valid", {63'd0, out_valid}, 64'd0);

      drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, '0);
      step(1);
      drive(1'b1, 4'h6, 4'h7, 64'd1, 64'd1, '0);
      step(1);
      check("illop_err", {63'd0, out_err}, 64'd1);
      check("illop_valE", valE, 64'd0);
      check("illop_halted", {63'd0, halted}, 64'd1);
      check("illop_cc_kept", {61'd0, cc}, 64'd0);
      step(2);
      check("halted_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b0; rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("unhalt_cc", {61'd0, cc}, 64'd4);
      check("unhalt_in_ready", {63'd0, in_ready}, 64'd1);

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, bad_ic[i], bad_fn[i], 64'd9, 64'd9, 64'd9);
         step(1);
         in_valid = 1'b0;
         check("halt_out_valid", {63'd0, out_valid}, 64'd1);
         check("halt_err", {63'd0, out_err}, {63'd0, bad_ic[i] != 4'h0});
         check("halt_state", {63'd0, halted}, 64'd1);
         step(1);
         rst = 1'b1;
         step(1);
         rst = 1'b0;
      end

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
